// File: rtl/shift_add_mul_pkg.sv
// shift_add_mul_pkg: FSM state encoding and default operand width for shift_add_mul
package shift_add_mul_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/shift_add_mul_add_w.sv
// add_w: WIDTH-bit combinational adder; ports x, y, cin in; s, cout out
module add_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  assign {cout, s} = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/shift_add_mul.sv
// shift_add_mul: sequential shift-add multiplier; in: clk rst in_valid a b out_ready, out: in_ready out_valid product; SHIFT_ADD_MUL_ZERO_BYPASS_EN skips steps for zero operands
module shift_add_mul
  import shift_add_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state;
  logic [WIDTH-1:0] mcand, acc_hi, mq, s;
  logic [CW-1:0] cnt;
  logic c, bypass;
  add_w #(.WIDTH(WIDTH)) u_add (
    .x(acc_hi),
    .y(mq[0] ? mcand : '0),
    .cin(1'b0),
    .s(s),
    .cout(c)
  );
`ifdef SHIFT_ADD_MUL_ZERO_BYPASS_EN
  assign bypass = (a == '0) || (b == '0);
`else
  assign bypass = 1'b0;
`endif
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mcand   <= '0;
      acc_hi  <= '0;
      mq      <= '0;
      product <= '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        mcand  <= a;
        mq     <= b;
        acc_hi <= '0;
        cnt    <= '0;
        state  <= bypass ? DONE : CALC;
        if (bypass) product <= '0;
      end
    end else if (state == CALC) begin
      acc_hi <= {c, s[WIDTH-1:1]};
      mq     <= {s[0], mq[WIDTH-1:1]};
      cnt    <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) begin
        state   <= DONE;
        product <= {c, s, mq[WIDTH-1:1]};
      end
    end else if (out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_shift_add_mul.sv
// tb_shift_add_mul: randomized and directed self-checking bench for shift_add_mul against an arithmetic model
module tb_shift_add_mul;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic in_ready, out_valid;
  logic [15:0] product;
  int n_chk = 0;
  int n_fail = 0;
`ifdef SHIFT_ADD_MUL_ZERO_BYPASS_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = 8;
`endif
  shift_add_mul #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
    return 16'(x) * 16'(y);
  endfunction
  function automatic int model_lat(input logic [7:0] x, input logic [7:0] y);
    return (x == 0 || y == 0) ? ZLAT : 8;
  endfunction
  // Offers one operand pair, returns edges from accept to out_valid and the product seen then
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, output int lat,
                        output logic [15:0] p, output logic to);
    int w = 0;
    to = 1'b0;
    lat = 0;
    while (!in_ready && w < 40) begin @(negedge clk); w++; end
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    to = !out_valid || w >= 40;
    p = product;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_chk++; if (product !== 16'h0) begin n_fail++; $display("FAIL reset_product got %h want 0000", product); end
  endtask
  task automatic test_directed();
    logic [7:0] xs [3] = '{8'd13, 8'hFF, 8'h00};
    logic [7:0] ys [3] = '{8'd11, 8'hFF, 8'h5A};
    int lat; logic [15:0] p; logic to;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_op(xs[i], ys[i], lat, p, to);
      n_chk++; if (to) begin n_fail++; $display("FAIL dir_timeout case %0d", i); end
      n_chk++; if (p !== model(xs[i], ys[i])) begin n_fail++; $display("FAIL dir_product case %0d got %h want %h", i, p, model(xs[i], ys[i])); end
      n_chk++; if (lat != model_lat(xs[i], ys[i])) begin n_fail++; $display("FAIL dir_latency case %0d got %0d want %0d", i, lat, model_lat(xs[i], ys[i])); end
      @(posedge clk); @(negedge clk);
      n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL dir_pulse case %0d got out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready); end
    end
  endtask
  task automatic test_backpressure();
    int lat; logic [15:0] p; logic to;
    out_ready = 1'b0;
    run_op(8'h80, 8'h02, lat, p, to);
    n_chk++; if (to || p !== 16'h0100) begin n_fail++; $display("FAIL bp_product got %h want 0100 (timeout=%b)", p, to); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'h33; b = 8'h44;
      @(posedge clk); @(negedge clk);
      n_chk++; if (out_valid !== 1'b1 || product !== 16'h0100 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold cycle %0d got out_valid=%b product=%h in_ready=%b want 1/0100/0", i, out_valid, product, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask
  task automatic test_reset_mid();
    int lat; logic [15:0] p; logic to;
    a = 8'd7; b = 8'd9; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h0) begin
      n_fail++; $display("FAIL midrst_state got in_ready=%b out_valid=%b product=%h want 1/0/0000", in_ready, out_valid, product);
    end
    run_op(8'd3, 8'd5, lat, p, to);
    n_chk++; if (to || p !== 16'h000F || lat != 8) begin n_fail++; $display("FAIL midrst_next got %h lat %0d want 000F lat 8", p, lat); end
    @(posedge clk); @(negedge clk);
  endtask
  task automatic test_ignore_busy();
    int lat = 0;
    a = 8'd2; b = 8'd3; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    a = 8'h11; b = 8'h22;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL busy_in_ready got %b want 0", in_ready); end
    while (!out_valid && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
    n_chk++; if (product !== 16'h0006 || lat != 8) begin n_fail++; $display("FAIL busy_first got %h lat %0d want 0006 lat 8", product, lat); end
    @(posedge clk); @(negedge clk);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL busy_idle got in_ready=%b want 1", in_ready); end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
    n_chk++; if (product !== 16'h0242 || lat != 8) begin n_fail++; $display("FAIL busy_second got %h lat %0d want 0242 lat 8", product, lat); end
    @(posedge clk); @(negedge clk);
  endtask
  task automatic test_back_to_back();
    int gap = 0;
    a = 8'd5; b = 8'd6; in_valid = 1'b1; out_ready = 1'b1;
    while (!out_valid && gap < 40) begin @(negedge clk); gap++; end
    gap = 0;
    do begin @(negedge clk); gap++; end while (!out_valid && gap < 40);
    in_valid = 1'b0;
    n_chk++; if (gap != 10 || product !== 16'd30) begin n_fail++; $display("FAIL b2b_throughput got gap %0d product %h want 10 001e", gap, product); end
    @(posedge clk); @(negedge clk);
  endtask
  task automatic test_random();
    int lat; logic [15:0] p; logic to;
    logic [7:0] x, y;
    for (int i = 0; i < 40; i++) begin
      x = 8'($urandom); y = 8'($urandom);
      if (i % 10 == 3) x = 8'h00;
      if (i % 10 == 7) y = 8'h00;
      out_ready = 1'b0;
      run_op(x, y, lat, p, to);
      n_chk++; if (to || p !== model(x, y) || lat != model_lat(x, y)) begin
        n_fail++; $display("FAIL rand_%0d a=%h b=%h got %h lat %0d want %h lat %0d", i, x, y, p, lat, model(x, y), model_lat(x, y));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_ignore_busy();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
